// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative multiply/divide unit covering the RISC-V M-extension ops.
// A multiply takes one shift-add step per cycle and a divide takes one restoring
// subtract-shift step per cycle, WIDTH steps in total, followed by a sign-fixup cycle.
// Optional macro MUL_DIV_SEQ_FAST_SPECIAL_EN: divide by zero and signed overflow
// skip the iteration and complete one cycle after start.
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2:0]         op;
  logic               neg;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;

  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               neg_start;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] neg_acc;
  logic [WIDTH-1:0]   neg_hi;
  logic [WIDTH-1:0]   fix_result;
  logic               fast;
  logic [WIDTH-1:0]   special_result;

  // Operand signedness per op, magnitudes, and the sign the final result must take
  always_comb begin
    sign_a    = 1'b0;
    sign_b    = 1'b0;
    neg_start = 1'b0;
    case (func3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sign_a = a[WIDTH-1];
        sign_b = b[WIDTH-1];
      end
      3'b010:  sign_a = a[WIDTH-1];
      default: ;
    endcase
    abs_a = sign_a ? (~a + 1'b1) : a;
    abs_b = sign_b ? (~b + 1'b1) : b;
    if (!func3[2])
      neg_start = sign_a ^ sign_b;
    else if (func3[1])
      neg_start = sign_a;
    else
      neg_start = (sign_a ^ sign_b) && (b != '0);
  end

  // One iteration step: shift-add for multiply, restoring subtract-shift for divide
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opb};
    step_acc = {mul_sum, acc[WIDTH-1:1]};
    if (op[2]) begin
      if (div_diff[WIDTH+1])
        step_acc = {acc[2*WIDTH-2:0], 1'b0};
      else
        step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction and half selection: low half holds product-low or quotient, high half holds product-high or remainder
  always_comb begin
    neg_acc    = ~acc + 1'b1;
    neg_hi     = ~acc[2*WIDTH-1:WIDTH] + 1'b1;
    fix_result = '0;
    if (!op[2]) begin
      if (op[1:0] == 2'b00)
        fix_result = neg ? neg_acc[WIDTH-1:0] : acc[WIDTH-1:0];
      else
        fix_result = neg ? neg_acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else if (!op[1]) begin
      fix_result = neg ? neg_acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      fix_result = neg ? neg_hi : acc[2*WIDTH-1:WIDTH];
    end
  end

`ifdef MUL_DIV_SEQ_FAST_SPECIAL_EN
  // Detect divide by zero and signed overflow at start and form their fixed results directly
  always_comb begin
    fast           = 1'b0;
    special_result = '0;
    if (func3[2]) begin
      if (b == '0) begin
        fast           = 1'b1;
        special_result = func3[1] ? a : {WIDTH{1'b1}};
      end else if (!func3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}})) begin
        fast           = 1'b1;
        special_result = func3[1] ? {WIDTH{1'b0}} : a;
      end
    end
  end
`else
  assign fast           = 1'b0;
  assign special_result = '0;
`endif

  // Control FSM with registered busy/done/result; reset beats flush, flush beats start
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      op     <= '0;
      neg    <= 1'b0;
      opb    <= '0;
      acc    <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op    <= func3;
            neg   <= neg_start;
            opb   <= abs_b;
            acc   <= {{WIDTH{1'b0}}, abs_a};
            count <= '0;
            if (fast) begin
              result <= special_result;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        CALC: begin
          acc   <= step_acc;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1))
            state <= FIXUP;
        end
        FIXUP: begin
          result <= fix_result;
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed testbench for mul_div_seq (WIDTH = 32) with hand-computed expected values.
// Honors MUL_DIV_SEQ_FAST_SPECIAL_EN for the expected latency of the special divide cases.
module tb_mul_div_seq;

  localparam int W = 32;
`ifdef MUL_DIV_SEQ_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = W + 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   func3 = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .func3(func3),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Launches one op from IDLE/DONE and waits (bounded) for done; latency counts from the start edge
  task automatic run_op(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] res, output int lat, output int busy_cnt);
    int n;
    @(negedge clk);
    func3 = f; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      n++;
      #1;
    end
    lat = n + 1;
    res = result;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", result); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [W-1:0] r; int lat; int bc;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mul_result: got %h want ffffffeb", r); end
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL mul_latency: got %0d want 34", lat); end
    checks++; if (bc !== 33) begin errors++; $display("[TB] FAIL mul_busy_cycles: got %0d want 33", bc); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mul_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_mulh();
    logic [W-1:0] r; int lat; int bc;
    run_op(3'b001, 32'h80000000, 32'h80000000, r, lat, bc);
    checks++; if (r !== 32'h40000000) begin errors++; $display("[TB] FAIL mulh: got %h want 40000000", r); end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu: got %h want fffffffe", r); end
    run_op(3'b010, 32'hFFFFFFFF, 32'd2, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulhsu: got %h want ffffffff", r); end
  endtask

  task automatic test_div();
    logic [W-1:0] r; int lat; int bc;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg: got %h want fffffffd", r); end
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL div_latency: got %0d want 34", lat); end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL rem_neg: got %h want ffffffff", r); end
    run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
    checks++; if (r !== 32'd14) begin errors++; $display("[TB] FAIL divu: got %h want 0000000e", r); end
    run_op(3'b111, 32'd100, 32'd7, r, lat, bc);
    checks++; if (r !== 32'd2) begin errors++; $display("[TB] FAIL remu: got %h want 00000002", r); end
  endtask

  task automatic test_special();
    logic [W-1:0] r; int lat; int bc;
    run_op(3'b101, 32'd5, 32'd0, r, lat, bc);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL divu_by_zero: got %h want ffffffff", r); end
    checks++; if (lat !== SPECIAL_LAT) begin errors++; $display("[TB] FAIL divu_by_zero_lat: got %0d want %0d", lat, SPECIAL_LAT); end
    run_op(3'b110, 32'd5, 32'd0, r, lat, bc);
    checks++; if (r !== 32'd5) begin errors++; $display("[TB] FAIL rem_by_zero: got %h want 00000005", r); end
    checks++; if (lat !== SPECIAL_LAT) begin errors++; $display("[TB] FAIL rem_by_zero_lat: got %0d want %0d", lat, SPECIAL_LAT); end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
    checks++; if (r !== 32'h80000000) begin errors++; $display("[TB] FAIL div_overflow: got %h want 80000000", r); end
    checks++; if (lat !== SPECIAL_LAT) begin errors++; $display("[TB] FAIL div_overflow_lat: got %0d want %0d", lat, SPECIAL_LAT); end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
    checks++; if (r !== 32'd0) begin errors++; $display("[TB] FAIL rem_overflow: got %h want 00000000", r); end
    checks++; if (lat !== SPECIAL_LAT) begin errors++; $display("[TB] FAIL rem_overflow_lat: got %0d want %0d", lat, SPECIAL_LAT); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r; int lat; int bc;
    run_op(3'b000, 32'd2, 32'd3, r, lat, bc);
    checks++; if (r !== 32'd6) begin errors++; $display("[TB] FAIL b2b_first: got %h want 00000006", r); end
    run_op(3'b101, 32'd81, 32'd9, r, lat, bc);
    checks++; if (r !== 32'd9) begin errors++; $display("[TB] FAIL b2b_second: got %h want 00000009", r); end
    checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL b2b_latency: got %0d want 34", lat); end
  endtask

  task automatic test_ignore_start();
    int n;
    @(negedge clk);
    func3 = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (n == 5) begin
        func3 = 3'b101; a = 32'd9; b = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      #1;
    end
    start = 1'b0;
    checks++; if (result !== 32'd42) begin errors++; $display("[TB] FAIL ignore_start_result: got %h want 0000002a", result); end
    checks++; if (n + 1 !== 34) begin errors++; $display("[TB] FAIL ignore_start_latency: got %0d want 34", n + 1); end
  endtask

  task automatic test_flush();
    bit saw_done;
    @(negedge clk);
    func3 = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
    saw_done = done;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_done: got %b want 0", saw_done); end
    checks++; if (result !== 32'd42) begin errors++; $display("[TB] FAIL flush_result_kept: got %h want 0000002a", result); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r; int lat; int bc;
    bit saw_done;
    @(negedge clk);
    func3 = 3'b000; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_busy: got %b want 0", busy); end
    checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_mid_result: got %h want 0", result); end
    saw_done = done;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_no_done: got %b want 0", saw_done); end
    run_op(3'b000, 32'd3, 32'd4, r, lat, bc);
    checks++; if (r !== 32'd12) begin errors++; $display("[TB] FAIL after_reset_mul: got %h want 0000000c", r); end
  endtask

  // Runs every scenario in order, then prints the summary
  initial begin
    $display("[TB] starting mul_div_seq bench");
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_ignore_start();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even and >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only when not busy.
REQ-005 SHALL have port flush  input  1  synchronous abort of the operation in progress.
REQ-006 SHALL have port func3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports a, b  input  WIDTH  operands rs1 and rs2.
REQ-008 SHALL have port busy  output  1  high while an operation is in flight.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-010 SHALL have port result  output  WIDTH  registered result, held until the next completion.

Function
REQ-011 SHALL implement states IDLE, CALC, FIXUP and DONE.
REQ-012 SHALL, in IDLE or DONE with start=1 and flush=0, latch func3, abs(a) and abs(b) (per op signedness) and the result sign, clear the counter, and go to CALC.
REQ-013 SHALL, in DONE without an accepted start, go to IDLE.
REQ-014 SHALL, in CALC, do one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, exactly WIDTH cycles, then go to FIXUP.
REQ-015 SHALL, in FIXUP, apply two's-complement sign correction, write result and go to DONE.
REQ-016 SHALL keep a 2*WIDTH-bit product: MUL returns the low half; MULH, MULHSU and MULHU return the high half (MULHSU: a signed, b unsigned).
REQ-017 SHALL give DIV/REM quotient truncated toward zero, with the remainder taking the sign of the dividend.
REQ-018 SHALL, on divide by zero, return quotient all-ones (DIV, DIVU) and remainder = a (REM, REMU).
REQ-019 SHALL, on signed overflow (a = most negative, b = -1), return quotient = a (DIV) and remainder 0 (REM).
REQ-020 SHALL assert done only in DONE; latency from the start-sampling edge to done high SHALL be WIDTH+2 cycles, except as set by REQ-029.
REQ-021 SHALL assert busy exactly in CALC and FIXUP.
REQ-022 SHALL ignore start while busy: no relatch, no effect on the current operation.
REQ-023 SHALL, on flush in any state, go to IDLE next cycle with done low and result unchanged; flush SHALL beat a simultaneous start.
REQ-024 SHALL accept back-to-back operations: start in the DONE cycle goes straight to CALC.

Reset
REQ-025 SHALL, on reset=1 at a clk edge, go to IDLE with busy=0, done=0, result=0 and counter=0.
REQ-026 SHALL let reset beat start and flush, and SHALL abandon any operation in flight with no done pulse.

Configuration
REQ-027 SHALL use macro MUL_DIV_SEQ_FAST_SPECIAL_EN.
REQ-028 SHALL, without the macro, run divide by zero and signed overflow through CALC and FIXUP with normal latency and the REQ-018/REQ-019 results.
REQ-029 SHALL, with the macro, detect those cases at start and go directly to DONE with the result written, so done is high 1 cycle after the start edge, with the same values.

Verification
REQ-030 SHALL cover: reset, then MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 34 cycles after the start edge, busy high for 33 of those cycles.
REQ-031 SHALL cover: MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-032 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; done at 34 cycles without the macro and 1 cycle with it.
REQ-034 SHALL cover: start pulsed mid-CALC -> ignored with result unchanged; flush at CALC cycle 10 -> IDLE next cycle, no done, previous result kept.
REQ-035 SHALL cover: reset asserted mid-CALC together with start -> IDLE, result 0, no done; a new MUL 3*4 afterwards -> 12.
